// File: rtl/data_island_scheduler.sv
// data_island_scheduler
// Sequences HDMI data island periods inside video blanking and arbitrates
// round-robin between NUM_SOURCES packet sources. An island is
//   preamble(8) + leading guard(2) + N x packet(32) + trailing guard(2)
// followed by MIN_CONTROL control cycles. An island, and every further packet
// in it, is started only if the remaining blanking window can hold it
// together with the closing guard band and the control period.
//
// Ports
//   clk_pixel          pixel clock, all logic on the rising edge
//   reset_n            synchronous reset, active low
//   blanking_window    high while control/data island periods are legal
//   window_remaining   blanking cycles left including the current one
//   packet_request     level request per source, held until granted
//   packet_grant       one-hot pulse in the first data cycle of a packet
//   packet_select      index of the source owning the current packet
//   packet_null        high for a whole packet that no source owns
//   mode               0 control, 1 preamble, 2 guard band, 3 data island
//   data_island_period high exactly when mode == 3
//   overrun            sticky: blanking ended inside an island
module data_island_scheduler #(
  parameter int NUM_SOURCES = 4,
  parameter int MAX_PACKETS = 18,
  parameter int MIN_CONTROL = 12
) (
  input  logic                           clk_pixel,
  input  logic                           reset_n,
  input  logic                           blanking_window,
  input  logic [11:0]                    window_remaining,
  input  logic [NUM_SOURCES-1:0]         packet_request,
  output logic [NUM_SOURCES-1:0]         packet_grant,
  output logic [$clog2(NUM_SOURCES)-1:0] packet_select,
  output logic                           packet_null,
  output logic [1:0]                     mode,
  output logic                           data_island_period,
  output logic                           overrun
);

  localparam int SEL_W = $clog2(NUM_SOURCES);
  localparam int PK_W  = $clog2(MAX_PACKETS + 1);
  // Counter covers the 32-cycle packet phase and the cooldown length.
  localparam int CNT_W = (MIN_CONTROL > 32) ? $clog2(MIN_CONTROL) : 5;

  // Cycles needed from the deciding cycle to the end of the control period.
  localparam logic [11:0] START_NEED = 12'(1 + 8 + 2 + 32 + 2 + MIN_CONTROL);
  localparam logic [11:0] CONT_NEED  = 12'(1 + 32 + 2 + MIN_CONTROL);

  typedef enum logic [1:0] {
    MODE_CONTROL  = 2'd0,
    MODE_PREAMBLE = 2'd1,
    MODE_GUARD    = 2'd2,
    MODE_ISLAND   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_LEAD_GUARD,
    S_PACKET,
    S_TRAIL_GUARD,
    S_COOLDOWN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   rr_ptr;
  logic [PK_W-1:0]    packets_sent;
  logic               last_packet;

  logic               any_req;
  logic [SEL_W:0]     arb_pick;
  logic               win_valid;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   next_ptr;
  logic               in_island;
  logic               lead_arb;
  logic               cont_ok;
  logic               take_grant;

  // Round-robin search starting at 'start'; returns {found, index}.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_SOURCES-1:0] req,
                                             input logic [SEL_W-1:0]       start);
    logic             found;
    logic [SEL_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      j = int'(start) + k;
      if (j >= NUM_SOURCES) j = j - NUM_SOURCES;
      if (!found && req[SEL_W'(j)]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
    return {found, idx};
  endfunction

  assign any_req   = |packet_request;
  assign arb_pick  = rr_pick(packet_request, rr_ptr);
  assign win_valid = arb_pick[SEL_W];
  assign win_idx   = arb_pick[SEL_W-1:0];

  // NOTE: every signal written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    next_ptr   = (win_idx == SEL_W'(NUM_SOURCES - 1)) ? '0 : win_idx + 1'b1;
    in_island  = (state == S_PREAMBLE) || (state == S_LEAD_GUARD) ||
                 (state == S_PACKET)   || (state == S_TRAIL_GUARD);
    lead_arb   = (state == S_LEAD_GUARD) && (cnt == CNT_W'(1));
    // A null first packet (last_packet) always closes the island.
    cont_ok    = (state == S_PACKET) && (cnt == CNT_W'(31)) && !last_packet &&
                 any_req && (packets_sent < PK_W'(MAX_PACKETS)) &&
                 (window_remaining >= CONT_NEED);
    take_grant = (lead_arb && win_valid) || cont_ok;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      cnt                <= '0;
      rr_ptr             <= '0;
      packets_sent       <= '0;
      last_packet        <= 1'b0;
      mode               <= MODE_CONTROL;
      data_island_period <= 1'b0;
      packet_grant       <= '0;
      packet_select      <= '0;
      packet_null        <= 1'b0;
      overrun            <= 1'b0;
    end else if (in_island && !blanking_window) begin
      // Blanking ended under us: drop straight to control, no cooldown.
      state              <= S_IDLE;
      cnt                <= '0;
      mode               <= MODE_CONTROL;
      data_island_period <= 1'b0;
      packet_grant       <= '0;
      packet_null        <= 1'b0;
      overrun            <= 1'b1;
    end else begin
      packet_grant <= '0;
      if (take_grant) begin
        packet_grant  <= NUM_SOURCES'(1) << win_idx;
        packet_select <= win_idx;
        packet_null   <= 1'b0;
        rr_ptr        <= next_ptr;
      end

      case (state)
        S_IDLE: begin
          if (blanking_window && any_req && (window_remaining >= START_NEED)) begin
            state <= S_PREAMBLE;
            cnt   <= '0;
            mode  <= MODE_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          if (cnt == CNT_W'(7)) begin
            state <= S_LEAD_GUARD;
            cnt   <= '0;
            mode  <= MODE_GUARD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LEAD_GUARD: begin
          if (cnt == CNT_W'(1)) begin
            state              <= S_PACKET;
            cnt                <= '0;
            mode               <= MODE_ISLAND;
            data_island_period <= 1'b1;
            packets_sent       <= PK_W'(1);
            // All requests withdrawn during the preamble: send one null packet.
            packet_null        <= !win_valid;
            last_packet        <= !win_valid;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PACKET: begin
          if (cnt == CNT_W'(31)) begin
            cnt <= '0;
            if (cont_ok) begin
              packets_sent <= packets_sent + 1'b1;
            end else begin
              state              <= S_TRAIL_GUARD;
              mode               <= MODE_GUARD;
              data_island_period <= 1'b0;
              packet_null        <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TRAIL_GUARD: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_COOLDOWN;
            cnt   <= '0;
            mode  <= MODE_CONTROL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (cnt == CNT_W'(MIN_CONTROL - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          mode  <= MODE_CONTROL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Self-checking bench for data_island_scheduler: table-driven start-threshold
// vectors, hand-written island sequences, then randomized stimulus compared
// cycle by cycle against a timeline-based reference model.
module tb_data_island_scheduler;

  localparam int NS = 4;

  logic          clk_pixel = 1'b0;
  logic          reset_n;
  logic          blanking_window;
  logic [11:0]   window_remaining;
  logic [NS-1:0] packet_request;
  logic [NS-1:0] packet_grant;
  logic [1:0]    packet_select;
  logic          packet_null;
  logic [1:0]    mode;
  logic          data_island_period;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_pixel = ~clk_pixel;

  data_island_scheduler #(
    .NUM_SOURCES(4), .MAX_PACKETS(18), .MIN_CONTROL(12)
  ) dut (
    .clk_pixel          (clk_pixel),
    .reset_n            (reset_n),
    .blanking_window    (blanking_window),
    .window_remaining   (window_remaining),
    .packet_request     (packet_request),
    .packet_grant       (packet_grant),
    .packet_select      (packet_select),
    .packet_null        (packet_null),
    .mode               (mode),
    .data_island_period (data_island_period),
    .overrun            (overrun)
  );

  // ---------------- reference model ----------------
  // An island is a timeline: t counts cycles from the first preamble cycle.
  // Packet k (1-based) occupies t = 10+32(k-1) .. 41+32(k-1); decisions are
  // taken at t = 9 + 32*npk. Once closed with n packets the trailing guard is
  // t < 12+32n and the cooldown ends at t = 24+32n.
  bit m_active, m_closed, m_ovr;
  int m_t, m_npk, m_n, m_ptr, m_owner, m_sel;

  function automatic int rr_model(input logic [3:0] r, input int p);
    for (int k = 0; k < NS; k++)
      if (r[(p + k) % NS]) return (p + k) % NS;
    return -1;
  endfunction

  task automatic model_grant();
    m_owner = rr_model(packet_request, m_ptr);
    m_sel   = m_owner;
    m_ptr   = (m_owner + 1) % NS;
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_active = 0; m_ptr = 0; m_sel = 0; m_ovr = 0; m_owner = -1;
      return;
    end
    if (!m_active) begin
      if (blanking_window && packet_request != 0 && window_remaining >= 57) begin
        m_active = 1; m_t = 0; m_npk = 0; m_closed = 0;
      end
      return;
    end
    if ((!m_closed || m_t < 12 + 32 * m_n) && !blanking_window) begin
      m_active = 0; m_ovr = 1;
      return;
    end
    if (!m_closed && m_t == 9 + 32 * m_npk) begin
      if (m_npk == 0) begin
        if (packet_request != 0) model_grant();
        else begin m_owner = -1; m_closed = 1; m_n = 1; end
        m_npk = 1;
      end else if (packet_request != 0 && m_npk < 18 && window_remaining >= 47) begin
        model_grant();
        m_npk++;
      end else begin
        m_closed = 1; m_n = m_npk;
      end
    end
    m_t++;
    if (m_closed && m_t == 24 + 32 * m_n) m_active = 0;
  endtask

  function automatic logic [10:0] model_out();
    logic [1:0] m;
    logic [3:0] g;
    logic       nl;
    m = 2'd0; g = 4'd0; nl = 1'b0;
    if (m_active) begin
      if (m_t < 8) m = 2'd1;
      else if (m_t < 10) m = 2'd2;
      else if (m_t < 10 + 32 * m_npk) begin
        m = 2'd3;
        if (m_owner >= 0 && (m_t - 10) % 32 == 0) g = 4'(1 << m_owner);
        nl = (m_owner < 0);
      end else if (m_t < 12 + 32 * m_npk) m = 2'd2;
    end
    return {m, (m == 2'd3), g, 2'(m_sel), nl, m_ovr};
  endfunction

  function automatic logic [10:0] dut_out();
    return {mode, data_island_period, packet_grant, packet_select, packet_null, overrun};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    model_step();
    @(negedge clk_pixel);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; blanking_window = 1'b0; window_remaining = '0; packet_request = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    for (int k = 0; k < NS; k++) if (g[k]) return k;
    return -1;
  endfunction

  // Sources 0 and 1 request; window_remaining counts down from w.
  task automatic run_window(input int w, input int exp_pk, input string tag);
    int dips;
    logic [1:0] mode42;
    do_reset();
    blanking_window = 1'b1; packet_request = 4'b0011; window_remaining = 12'(w);
    dips = 0; mode42 = 2'd0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (packet_grant != 0) packet_request = packet_request & ~packet_grant;
      if (data_island_period) dips++;
      if (i == 42) mode42 = mode;
      if (window_remaining > 0) window_remaining = window_remaining - 1'b1;
    end
    check({tag, "_dip_cycles"}, 32'(dips), 32'(32 * exp_pk));
    check({tag, "_mode_after_pkt1"}, 32'(mode42), (exp_pk == 1) ? 32'd2 : 32'd3);
  endtask

  typedef struct {
    logic       blank;
    logic [3:0] req;
    logic [11:0] wr;
    logic [1:0] exp_mode;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dips, rises, nulls, grants, idx;
    logic prev_dip;
    int order [$];

    vecs[0] = '{1'b1, 4'b0001, 12'd56,   2'd0};
    vecs[1] = '{1'b1, 4'b0001, 12'd57,   2'd1};
    vecs[2] = '{1'b0, 4'b0001, 12'd200,  2'd0};
    vecs[3] = '{1'b1, 4'b0000, 12'd200,  2'd0};
    vecs[4] = '{1'b1, 4'b1000, 12'd4095, 2'd1};
    vecs[5] = '{1'b1, 4'b0100, 12'd0,    2'd0};

    m_active = 0; m_closed = 0; m_ovr = 0; m_t = 0; m_npk = 0; m_n = 0;
    m_ptr = 0; m_owner = -1; m_sel = 0;

    do_reset();
    check("reset_state", 32'(dut_out()), 32'd0);

    // Start-threshold table.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      blanking_window = vecs[v].blank; packet_request = vecs[v].req;
      window_remaining = vecs[v].wr;
      tick();
      check($sformatf("start_vec[%0d]", v), 32'(mode), 32'(vecs[v].exp_mode));
    end

    // Source 2 alone: full mode sequence, one grant, select held.
    do_reset();
    blanking_window = 1'b1; packet_request = 4'b0100; window_remaining = 12'd200;
    for (int i = 0; i < 56; i++) begin
      logic [1:0] em;
      tick();
      em = (i < 8) ? 2'd1 : (i < 10) ? 2'd2 : (i < 42) ? 2'd3 : (i < 44) ? 2'd2 : 2'd0;
      check($sformatf("single_mode[%0d]", i), 32'(mode), 32'(em));
      if (i >= 10 && i < 42) begin
        check($sformatf("single_grant[%0d]", i), 32'(packet_grant),
              (i == 10) ? 32'h4 : 32'h0);
        check($sformatf("single_select[%0d]", i), 32'(packet_select), 32'd2);
      end
      if (packet_grant != 0) packet_request = packet_request & ~packet_grant;
    end

    // All four sources: four packets in order 0..3, one contiguous 128 run.
    do_reset();
    blanking_window = 1'b1; packet_request = 4'b1111; window_remaining = 12'd500;
    dips = 0; rises = 0; prev_dip = 1'b0;
    for (int i = 0; i < 152; i++) begin
      tick();
      if (packet_grant != 0) begin
        order.push_back(onehot_idx(packet_grant));
        packet_request = packet_request & ~packet_grant;
      end
      if (data_island_period) dips++;
      if (data_island_period && !prev_dip) rises++;
      prev_dip = data_island_period;
    end
    check("rr_grant_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size(); k++)
      check($sformatf("rr_order[%0d]", k), 32'(order[k]), 32'(k));
    check("rr_dip_cycles", 32'(dips), 32'd128);
    check("rr_dip_runs", 32'(rises), 32'd1);
    check("rr_back_to_idle", 32'(mode), 32'd0);
    packet_request = 4'b1111;
    idx = -1;
    for (int i = 0; i < 40 && idx < 0; i++) begin
      tick();
      if (packet_grant != 0) idx = onehot_idx(packet_grant);
    end
    check("rr_wrap_first_grant", 32'(idx), 32'd0);

    // Continue boundary: 46 at phase 31 ends the island, 47 continues.
    run_window(88, 1, "cont46");
    run_window(89, 2, "cont47");

    // Null packet: source 3 withdraws during the preamble. No reset, so the
    // select left at 1 by the previous island must be held.
    blanking_window = 1'b1; packet_request = 4'b1000; window_remaining = 12'd300;
    nulls = 0; grants = 0; dips = 0;
    for (int i = 0; i < 56; i++) begin
      tick();
      if (i == 2) packet_request = 4'b0000;
      if (packet_null) nulls++;
      if (packet_grant != 0) grants++;
      if (data_island_period) dips++;
      if (i == 20) check("null_select_held", 32'(packet_select), 32'd1);
      if (i == 42) check("null_then_trail", 32'(mode), 32'd2);
    end
    check("null_cycles", 32'(nulls), 32'd32);
    check("null_grants", 32'(grants), 32'd0);
    check("null_dip_cycles", 32'(dips), 32'd32);

    // Blanking drops at packet phase 10.
    do_reset();
    blanking_window = 1'b1; packet_request = 4'b0010; window_remaining = 12'd300;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (packet_grant != 0) packet_request = packet_request & ~packet_grant;
    end
    check("ovr_in_packet", 32'(mode), 32'd3);
    blanking_window = 1'b0;
    tick();
    check("ovr_outputs", 32'(dut_out()), 32'({2'd0, 1'b0, 4'd0, 2'd1, 1'b0, 1'b1}));
    blanking_window = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-packet clears everything at the next edge.
    do_reset();
    blanking_window = 1'b1; packet_request = 4'b0001; window_remaining = 12'd300;
    for (int i = 0; i < 25; i++) tick();
    check("rst_in_packet", 32'(mode), 32'd3);
    reset_n = 1'b0;
    tick();
    check("rst_mid_packet", 32'(dut_out()), 32'd0);
    reset_n = 1'b1;

    // Randomized stimulus against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset_n         = ($urandom_range(0, 699) != 0);
      blanking_window = ($urandom_range(0, 499) != 0);
      window_remaining = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(40, 64))
                                                     : 12'($urandom_range(0, 600));
      if ($urandom_range(0, 5) == 0)
        packet_request = packet_request ^ 4'(1 << $urandom_range(0, 3));
      tick();
      check($sformatf("rand[%0d]", c), 32'(dut_out()), 32'(model_out()));
      if (packet_grant != 0 && $urandom_range(0, 1) == 1)
        packet_request = packet_request & ~packet_grant;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_island_scheduler.md
Name: data_island_scheduler

Overview:
- Sequences HDMI data island periods inside video blanking and arbitrates between NUM_SOURCES packet sources (ACR, audio sample, InfoFrames, ...).
- Drives the period/mode signals that frame the packet assembler and TMDS channel muxes.
- Emits the per-packet grant and the select index that steer header/subpacket muxing into the assembler.
- Guarantees every island fits within the remaining blanking window: preamble + leading guard + N packets + trailing guard + minimum control period.

Parameters:
- NUM_SOURCES, 4, number of packet requesters; index 0 is highest priority on reset.
- MAX_PACKETS, 18, maximum packets per data island.
- MIN_CONTROL, 12, minimum control-period cycles after an island before another may start.

Ports:
- clk_pixel  in  1  pixel clock; all logic on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- blanking_window  in  1  high while the video timing is in blanking, where control or data island periods are legal.
- window_remaining  in  12  blanking cycles left, including the current cycle; don't-care when blanking_window=0.
- packet_request  in  NUM_SOURCES  level request per source; a source holds it until granted or it withdraws.
- packet_grant  out  NUM_SOURCES  one-hot, single-cycle pulse in the first data cycle of the granted packet.
- packet_select  out  $clog2(NUM_SOURCES)  index of the source owning the current packet; held for all 32 cycles.
- packet_null  out  1  high for the whole packet when no source owns it (downstream sends a null packet).
- mode  out  2  0=control, 1=data preamble, 2=data guard band, 3=data island.
- data_island_period  out  1  equals (mode==3).
- overrun  out  1  sticky error flag: blanking ended during an island; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE, mode=0, data_island_period=0, packet_grant=0, packet_select=0, packet_null=0, overrun=0.
  - Cooldown counter is preset so that an island may start on the first cycle after reset.
  - Round-robin pointer is set to 0.
  - Reset mid-island aborts immediately; there is no trailing guard.
- Constants:
  - START_NEED = 1+8+2+32+2+MIN_CONTROL, 57 at default.
  - CONT_NEED = 1+32+2+MIN_CONTROL, 47 at default.
- States:
  - IDLE (mode 0).
  - PREAMBLE: 8 cycles, mode 1.
  - LEAD_GUARD: 2 cycles, mode 2.
  - PACKET: 32 cycles, mode 3; 5-bit phase counter 0..31 wraps.
  - TRAIL_GUARD: 2 cycles, mode 2.
  - COOLDOWN: MIN_CONTROL cycles, mode 0. Then back to IDLE.
- IDLE -> PREAMBLE when blanking_window=1 AND |packet_request AND window_remaining >= START_NEED. Otherwise stay in IDLE.
- Arbitration:
  - Happens in the last LEAD_GUARD cycle and in PACKET phase 31.
  - Round-robin over the requests sampled in that cycle, starting at pointer, where pointer = last granted index + 1 mod NUM_SOURCES.
  - The winner is registered. The next cycle is the new packet's phase 0, with packet_grant[winner]=1, packet_select=winner, packet_null=0.
  - The pointer updates on each grant only.
- If no request exists at the last LEAD_GUARD cycle (all withdrawn during the preamble):
  - The first packet is null: packet_null=1, packet_grant=0, packet_select holds its previous value.
  - The island then closes after this packet.
- PACKET phase 31, continue rule: if |packet_request AND packets_sent < MAX_PACKETS AND window_remaining >= CONT_NEED, the next cycle starts another PACKET. Else go to TRAIL_GUARD.
  - packets_sent counts both granted and null packets.
- Sources sample packet_select and hold header/subpackets stable for the 32 cycles starting at their grant. A source may drop its request from the grant cycle onward.
- A request withdrawn before arbitration gets no grant. A request asserted in the same cycle as arbitration is eligible.
- blanking_window=0 while in PREAMBLE, LEAD_GUARD, PACKET or TRAIL_GUARD:
  - Set overrun=1 and go to IDLE next cycle with all outputs at control values.
  - This skips cooldown. Not reachable with a correct window_remaining.
- data_island_period goes high for exactly 32×N contiguous cycles per island.

Test Plan:
- Source 2 requests alone, window_remaining=200 in IDLE:
  - mode sequence 1×8, 2×2, 3×32, 2×2, 0×12.
  - packet_grant=4'b0100 pulses on the first mode-3 cycle; packet_select=2 for all 32 cycles.
- window_remaining=56 with source 0 requesting: no island starts. window_remaining=57: the island starts the next cycle.
- All four sources request continuously, window_remaining=500:
  - 4 packets back-to-back, grants in order 0,1,2,3, with data_island_period high for 128 contiguous cycles.
  - A second island then begins its grants with index 0 again (pointer wrapped).
- Sources 0 and 1 request and window_remaining is such that it equals 46 at the first packet's phase 31: only one packet, then TRAIL_GUARD.
- Source 3 drops its request during PREAMBLE: one null packet (packet_null=1 for 32 cycles, no grant), then trailing guard.
- blanking_window forced low at PACKET phase 10: next cycle mode=0, data_island_period=0, overrun=1 and it stays set.
  - Separately, reset_n=0 mid-packet clears all outputs at the next edge.
